// File: rtl/wbp_serialize_pkg.sv
// ----------------------------------------------------------------------------
// wbp_serialize_pkg
//   Shared definitions for the pipelined-Wishbone request serializer:
//   the downstream sequencing state encoding and the width of one queued
//   request entry {we, addr, data, sel}.
// ----------------------------------------------------------------------------
package wbp_serialize_pkg;

    // Downstream sequencing states.
    //   ST_IDLE  : nothing in flight downstream
    //   ST_ISSUE : strobe presented, waiting for !stall
    //   ST_WAIT  : strobe taken, waiting for ack/err
    //   ST_ERR   : bus error reported, hold until the master drops cyc
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // Bits in one queued request: we + address + write data + byte selects.
    function automatic int req_width(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

endpackage

// File: rtl/wbp_req_fifo.sv
// ----------------------------------------------------------------------------
// wbp_req_fifo
//   Synchronous request FIFO, 2^LGDEPTH entries of WIDTH bits, with a
//   show-ahead read port (rd_data is the current head).
//
// Ports
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   flush    in   empty the FIFO at the next edge; wins over a same-cycle push
//   push     in   write wr_data (ignored when full)
//   pop      in   drop the head entry (ignored when empty)
//   wr_data  in   entry to write
//   rd_data  out  head entry
//   full     out  no free slot
//   empty    out  no valid entry
// ----------------------------------------------------------------------------
module wbp_req_fifo
    import wbp_serialize_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LGDEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << LGDEPTH;

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit separates "full" from "empty" when the indices match.
    logic [LGDEPTH:0] wr_ptr;
    logic [LGDEPTH:0] rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[LGDEPTH] != rd_ptr[LGDEPTH]) &&
                     (wr_ptr[LGDEPTH-1:0] == rd_ptr[LGDEPTH-1:0]);
    assign rd_data = mem[rd_ptr[LGDEPTH-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; validity is tracked entirely by
    // the pointers, so stale contents are never observed as live entries.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[LGDEPTH-1:0]] <= wr_data;
    end

endmodule

// File: rtl/wbp_serialize.sv
// ----------------------------------------------------------------------------
// wbp_serialize
//   Pipelined-Wishbone front end for a single-outstanding downstream stage.
//   Queues up to 2^LGFIFO master requests and issues them downstream one at a
//   time, waiting for each ack/err before the next strobe. Acks return to the
//   master in order; a bus error discards the rest of the queue and stalls
//   the master until it drops cyc.
//
// Build option
//   WBP_SERIALIZE_LOWPOWER_EN : when defined, o_saddr/o_sdata/o_ssel are
//   forced to zero while o_sstb is low; otherwise they always show the FIFO
//   head.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_mcyc/i_mstb/i_mwe       master cycle, strobe, write enable
//   i_maddr/i_mdata/i_msel    master address, write data, byte selects
//   o_mstall/o_mack/o_merr    master stall, ack, bus error
//   o_mdata                   master read data
//   o_scyc/o_sstb/o_swe       downstream cycle, strobe, write enable
//   o_saddr/o_sdata/o_ssel    downstream address, write data, byte selects
//   i_sstall/i_sack/i_serr    downstream stall, ack, error
//   i_sdata                   downstream read data
// ----------------------------------------------------------------------------
module wbp_serialize
    import wbp_serialize_pkg::*;
#(
    parameter int AW     = 12,
    parameter int DW     = 32,
    parameter int LGFIFO = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_mcyc,
    input  logic            i_mstb,
    input  logic            i_mwe,
    input  logic [AW-1:0]   i_maddr,
    input  logic [DW-1:0]   i_mdata,
    input  logic [DW/8-1:0] i_msel,
    output logic            o_mstall,
    output logic            o_mack,
    output logic            o_merr,
    output logic [DW-1:0]   o_mdata,
    output logic            o_scyc,
    output logic            o_sstb,
    output logic            o_swe,
    output logic [AW-1:0]   o_saddr,
    output logic [DW-1:0]   o_sdata,
    output logic [DW/8-1:0] o_ssel,
    input  logic            i_sstall,
    input  logic            i_sack,
    input  logic            i_serr,
    input  logic [DW-1:0]   i_sdata
);

    localparam int REQ_W = req_width(AW, DW);
    localparam int DEPTH = 1 << LGFIFO;
    localparam logic [LGFIFO:0] FULL_COUNT = (LGFIFO + 1)'(DEPTH);

    state_t            state;
    logic [LGFIFO:0]   count;      // accepted but not yet acked/erred
    logic              cur_we;     // we of the transaction in WAIT

    logic              accept;
    logic              push;
    logic              pop;
    logic              flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [REQ_W-1:0]  head;
    logic              head_we;
    logic [AW-1:0]     head_addr;
    logic [DW-1:0]     head_data;
    logic [DW/8-1:0]   head_sel;

    assign o_mstall = (count == FULL_COUNT) || (state == ST_ERR);
    assign accept   = i_mcyc && i_mstb && !o_mstall;
    // count never exceeds the FIFO depth, so fifo_full is only a safety net.
    assign push     = accept && !fifo_full;
    assign pop      = (state == ST_ISSUE) && !i_sstall;
    // Dropping cyc, reset, or a downstream error all abandon the queue.
    assign flush    = !i_mcyc || (state == ST_WAIT && i_serr);

    wbp_req_fifo #(
        .WIDTH   (REQ_W),
        .LGDEPTH (LGFIFO)
    ) u_fifo (
        .clk     (i_clk),
        .reset   (i_reset),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data ({i_mwe, i_maddr, i_mdata, i_msel}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {head_we, head_addr, head_data, head_sel} = head;

    assign o_scyc = i_mcyc && ((state != ST_IDLE) || !fifo_empty);
    // The head entry is popped when the strobe is taken, so the write enable
    // for the WAIT phase comes from the copy captured at that moment.
    assign o_swe  = (state == ST_ISSUE) ? head_we : cur_we;

`ifdef WBP_SERIALIZE_LOWPOWER_EN
    assign o_saddr = o_sstb ? head_addr : '0;
    assign o_sdata = o_sstb ? head_data : '0;
    assign o_ssel  = o_sstb ? head_sel  : '0;
`else
    assign o_saddr = head_addr;
    assign o_sdata = head_data;
    assign o_ssel  = head_sel;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            cur_we  <= 1'b0;
            o_sstb  <= 1'b0;
            o_mack  <= 1'b0;
            o_merr  <= 1'b0;
            o_mdata <= '0;
        end else if (!i_mcyc) begin
            // Master abandoned the cycle: forget everything, ignore any
            // downstream response landing this cycle. o_mdata holds.
            state  <= ST_IDLE;
            count  <= '0;
            o_sstb <= 1'b0;
            o_mack <= 1'b0;
            o_merr <= 1'b0;
        end else begin
            o_mack <= 1'b0;
            o_merr <= 1'b0;

            case ({accept, o_mack || o_merr})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                ST_IDLE: begin
                    // A same-cycle push is already the head at the next edge,
                    // which gives the one-cycle accept-to-strobe latency.
                    if (!fifo_empty || push) begin
                        state  <= ST_ISSUE;
                        o_sstb <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!i_sstall) begin
                        state  <= ST_WAIT;
                        o_sstb <= 1'b0;
                        cur_we <= head_we;
                    end
                end
                ST_WAIT: begin
                    // Error wins when ack and err arrive together.
                    if (i_serr) begin
                        state  <= ST_ERR;
                        o_merr <= 1'b1;
                    end else if (i_sack) begin
                        state   <= ST_IDLE;
                        o_mack  <= 1'b1;
                        o_mdata <= i_sdata;
                    end
                end
                ST_ERR: begin
                    // Leaves only through the cyc-drop branch above.
                    state <= ST_ERR;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbp_serialize.sv
// ----------------------------------------------------------------------------
// tb_wbp_serialize
//   Self-checking bench for wbp_serialize (AW=12, DW=32, LGFIFO=2).
// ----------------------------------------------------------------------------
module tb_wbp_serialize;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_mcyc, i_mstb, i_mwe;
    logic [11:0] i_maddr;
    logic [31:0] i_mdata;
    logic [3:0]  i_msel;
    logic        o_mstall, o_mack, o_merr;
    logic [31:0] o_mdata;
    logic        o_scyc, o_sstb, o_swe;
    logic [11:0] o_saddr;
    logic [31:0] o_sdata;
    logic [3:0]  o_ssel;
    logic        i_sstall, i_sack, i_serr;
    logic [31:0] i_sdata;

    int n_tests = 0;
    int n_fail  = 0;

    int          acc_cyc [8];
    int          first_mack_cyc;
    logic [7:0]  stall_mask;

    always #5 i_clk = ~i_clk;

    wbp_serialize #(.AW(12), .DW(32), .LGFIFO(2)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_mcyc   (i_mcyc),
        .i_mstb   (i_mstb),
        .i_mwe    (i_mwe),
        .i_maddr  (i_maddr),
        .i_mdata  (i_mdata),
        .i_msel   (i_msel),
        .o_mstall (o_mstall),
        .o_mack   (o_mack),
        .o_merr   (o_merr),
        .o_mdata  (o_mdata),
        .o_scyc   (o_scyc),
        .o_sstb   (o_sstb),
        .o_swe    (o_swe),
        .o_saddr  (o_saddr),
        .o_sdata  (o_sdata),
        .o_ssel   (o_ssel),
        .i_sstall (i_sstall),
        .i_sack   (i_sack),
        .i_serr   (i_serr),
        .i_sdata  (i_sdata)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] wpat(input int k);
        return 32'h5000_0000 + 32'(k);
    endfunction

    function automatic logic [3:0] selpat(input int k);
        logic [1:0] s;
        s = 2'(k);
        return 4'b0001 << s;
    endfunction

    // One cycle per record: inputs for the cycle and the outputs expected
    // during it (registered outputs reflect earlier records).
    typedef struct {
        logic        mcyc, mstb;
        logic [11:0] maddr;
        logic        sstall, sack, serr;
        logic [31:0] sdata;
        logic        e_mstall, e_mack, e_merr, e_sstb, e_scyc;
        logic [31:0] e_mdata;
        logic [11:0] e_saddr;
    } vec_t;

    function automatic vec_t mk(input logic cyc, input logic stb, input logic [11:0] a,
                                input logic st, input logic ak, input logic er,
                                input logic [31:0] sd,
                                input logic e_st, input logic e_ak, input logic e_er,
                                input logic e_sb, input logic e_sc,
                                input logic [31:0] e_md, input logic [11:0] e_sa);
        vec_t v;
        v.mcyc = cyc;  v.mstb = stb;  v.maddr = a;
        v.sstall = st; v.sack = ak;   v.serr = er;  v.sdata = sd;
        v.e_mstall = e_st; v.e_mack = e_ak; v.e_merr = e_er;
        v.e_sstb = e_sb;   v.e_scyc = e_sc; v.e_mdata = e_md; v.e_saddr = e_sa;
        return v;
    endfunction

    // Master issues n requests back to back; slave stalls each strobe
    // stall_cyc cycles and acks ack_dly+1 cycles after taking it.
    task automatic run_burst(input int n, input logic we, input logic [11:0] base,
                             input int stall_cyc, input int ack_dly, input string tag);
        int          idx, cyc, stall_cnt, ack_cnt, mack_cnt, sidx, err_cnt;
        logic        ack_pend, took;
        logic [11:0] cur_addr;
        idx = 0; cyc = 0; stall_cnt = 0; ack_cnt = 0; mack_cnt = 0; sidx = 0; err_cnt = 0;
        ack_pend = 1'b0; cur_addr = '0;
        stall_mask = '0; first_mack_cyc = -1;
        while ((idx < n || mack_cnt < n) && cyc < 400) begin
            i_mcyc  = 1'b1;
            i_mstb  = (idx < n);
            i_mwe   = we;
            i_maddr = base + 12'(idx);
            i_mdata = wpat(idx);
            i_msel  = selpat(idx);
            i_sack  = 1'b0;
            i_serr  = 1'b0;
            if (ack_pend) begin
                if (ack_cnt == 0) begin
                    i_sack   = 1'b1;
                    i_sdata  = 32'hCAFE_0000 | {20'h0, cur_addr};
                    ack_pend = 1'b0;
                end else begin
                    ack_cnt--;
                end
            end
            i_sstall = o_sstb && (stall_cnt < stall_cyc);
            @(negedge i_clk);
            took = 1'b0;
            if (i_mstb) begin
                if (!o_mstall) begin
                    took = 1'b1;
                    acc_cyc[idx] = cyc;
                end else begin
                    stall_mask[idx] = 1'b1;
                end
            end
            if (o_sstb) begin
                check({tag, ".overlap"}, 32'(ack_pend), 32'h0);
                if (i_sstall) begin
                    stall_cnt++;
                end else begin
                    check($sformatf("%s.saddr%0d", tag, sidx), 32'(o_saddr), 32'(base + 12'(sidx)));
                    check($sformatf("%s.swe%0d", tag, sidx), 32'(o_swe), 32'(we));
                    if (we) begin
                        check($sformatf("%s.sdata%0d", tag, sidx), o_sdata, wpat(sidx));
                        check($sformatf("%s.ssel%0d", tag, sidx), 32'(o_ssel), 32'(selpat(sidx)));
                    end
                    cur_addr  = o_saddr;
                    sidx++;
                    stall_cnt = 0;
                    ack_pend  = 1'b1;
                    ack_cnt   = ack_dly;
                end
            end
            if (o_mack) begin
                if (mack_cnt == 0)
                    first_mack_cyc = cyc;
                if (!we)
                    check($sformatf("%s.mdata%0d", tag, mack_cnt), o_mdata,
                          32'hCAFE_0000 | {20'h0, base + 12'(mack_cnt)});
                mack_cnt++;
            end
            if (o_merr)
                err_cnt++;
            @(posedge i_clk); #1;
            if (took)
                idx++;
            cyc++;
        end
        i_mstb = 1'b0; i_sack = 1'b0; i_sstall = 1'b0;
        check({tag, ".mack_count"}, 32'(mack_cnt), 32'(n));
        check({tag, ".strobe_count"}, 32'(sidx), 32'(n));
        check({tag, ".merr_count"}, 32'(err_cnt), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [15];
        // single read to 0x010, ack 2 cycles after the strobe
        vecs[0]  = mk(1, 1, 12'h010, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        12'h000);
        vecs[1]  = mk(1, 0, 12'h000, 0, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h0,        12'h010);
        vecs[2]  = mk(1, 0, 12'h000, 0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h0,        12'h000);
        vecs[3]  = mk(1, 0, 12'h000, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'h0,        12'h000);
        vecs[4]  = mk(1, 0, 12'h000, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0, 32'hDEADBEEF, 12'h000);
        vecs[5]  = mk(0, 0, 12'h000, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'hDEADBEEF, 12'h000);
        // three queued reads; ack+err together on the first is an error
        vecs[6]  = mk(1, 1, 12'h020, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'hDEADBEEF, 12'h000);
        vecs[7]  = mk(1, 1, 12'h021, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'hDEADBEEF, 12'h020);
        vecs[8]  = mk(1, 1, 12'h022, 0, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'hDEADBEEF, 12'h020);
        vecs[9]  = mk(1, 0, 12'h000, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'hDEADBEEF, 12'h000);
        vecs[10] = mk(1, 1, 12'h023, 0, 0, 0, 32'h0,        1, 0, 1, 0, 1, 32'hDEADBEEF, 12'h000);
        vecs[11] = mk(1, 0, 12'h000, 0, 0, 0, 32'h0,        1, 0, 0, 0, 1, 32'hDEADBEEF, 12'h000);
        vecs[12] = mk(0, 0, 12'h000, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 32'hDEADBEEF, 12'h000);
        vecs[13] = mk(1, 0, 12'h000, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'hDEADBEEF, 12'h000);
        vecs[14] = mk(1, 0, 12'h000, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'hDEADBEEF, 12'h000);

        i_reset = 1'b1; i_mcyc = 1'b0; i_mstb = 1'b0; i_mwe = 1'b0;
        i_maddr = '0; i_mdata = '0; i_msel = 4'hF;
        i_sstall = 1'b0; i_sack = 1'b0; i_serr = 1'b0; i_sdata = '0;
        repeat (2) begin @(posedge i_clk); #1; end
        @(negedge i_clk);
        check("reset.mack",   32'(o_mack),   32'h0);
        check("reset.merr",   32'(o_merr),   32'h0);
        check("reset.sstb",   32'(o_sstb),   32'h0);
        check("reset.scyc",   32'(o_scyc),   32'h0);
        check("reset.mstall", 32'(o_mstall), 32'h0);
        check("reset.mdata",  o_mdata,       32'h0);
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        for (int r = 0; r < 15; r++) begin
            i_mcyc = vecs[r].mcyc; i_mstb = vecs[r].mstb; i_mwe = 1'b0;
            i_maddr = vecs[r].maddr; i_mdata = '0; i_msel = 4'hF;
            i_sstall = vecs[r].sstall; i_sack = vecs[r].sack;
            i_serr = vecs[r].serr; i_sdata = vecs[r].sdata;
            @(negedge i_clk);
            check($sformatf("vec%0d.mstall", r), 32'(o_mstall), 32'(vecs[r].e_mstall));
            check($sformatf("vec%0d.mack", r),   32'(o_mack),   32'(vecs[r].e_mack));
            check($sformatf("vec%0d.merr", r),   32'(o_merr),   32'(vecs[r].e_merr));
            check($sformatf("vec%0d.sstb", r),   32'(o_sstb),   32'(vecs[r].e_sstb));
            check($sformatf("vec%0d.scyc", r),   32'(o_scyc),   32'(vecs[r].e_scyc));
            check($sformatf("vec%0d.mdata", r),  o_mdata,       vecs[r].e_mdata);
            if (vecs[r].e_sstb)
                check($sformatf("vec%0d.saddr", r), 32'(o_saddr), 32'(vecs[r].e_saddr));
            @(posedge i_clk); #1;
        end
        i_mcyc = 1'b0; i_sack = 1'b0; i_serr = 1'b0;
        @(posedge i_clk); #1;

        // 4 back-to-back writes, one stall cycle per strobe
        run_burst(4, 1'b1, 12'h100, 1, 0, "wr4");
        check("wr4.stall_mask", 32'(stall_mask), 32'h0);
        i_mcyc = 1'b0;
        @(posedge i_clk); #1;

        // 5 reads against a slow slave: 5th stalls until the first ack returns
        run_burst(5, 1'b0, 12'h040, 0, 10, "bp5");
        check("bp5.stall_mask", 32'(stall_mask), 32'h10);
        check("bp5.accept5_cycle", 32'(acc_cyc[4]), 32'(first_mack_cyc + 1));
        i_mcyc = 1'b0;
        @(posedge i_clk); #1;

        // cyc drop in WAIT with two entries still queued; acks afterwards ignored
        i_mcyc = 1'b1; i_mwe = 1'b0; i_sstall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_mstb = 1'b1;
            i_maddr = 12'h200 + 12'(k);
            @(posedge i_clk); #1;
        end
        i_mstb = 1'b0; i_mcyc = 1'b0; i_sack = 1'b1; i_sdata = 32'h0BAD_0BAD;
        @(posedge i_clk); #1;
        i_mcyc = 1'b1;
        @(negedge i_clk);
        check("drop.scyc",  32'(o_scyc), 32'h0);
        check("drop.mack",  32'(o_mack), 32'h0);
        check("drop.sstb",  32'(o_sstb), 32'h0);
        @(posedge i_clk); #1;
        i_sack = 1'b0;
        @(negedge i_clk);
        check("drop.late_ack", 32'(o_mack), 32'h0);
        check("drop.no_issue", 32'(o_sstb), 32'h0);
        check("drop.empty",    32'(o_scyc), 32'h0);
        check("drop.mdata",    o_mdata,     32'hCAFE_0044);
        @(posedge i_clk); #1;
        i_mcyc = 1'b0;
        @(posedge i_clk); #1;

        // reset while a strobe is stalled in ISSUE
        i_mcyc = 1'b1; i_mstb = 1'b1; i_mwe = 1'b0; i_maddr = 12'h300;
        @(posedge i_clk); #1;
        i_mstb = 1'b0; i_sstall = 1'b1;
        @(negedge i_clk);
        check("rst.in_issue", 32'(o_sstb), 32'h1);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0; i_sstall = 1'b0;
        @(negedge i_clk);
        check("rst.sstb",   32'(o_sstb),   32'h0);
        check("rst.scyc",   32'(o_scyc),   32'h0);
        check("rst.mack",   32'(o_mack),   32'h0);
        check("rst.merr",   32'(o_merr),   32'h0);
        check("rst.mstall", 32'(o_mstall), 32'h0);
        check("rst.mdata",  o_mdata,       32'h0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("rst.no_reissue", 32'(o_sstb), 32'h0);
        @(posedge i_clk); #1;
        run_burst(1, 1'b0, 12'h3A0, 0, 1, "post_rst");
        i_mcyc = 1'b0;
        @(posedge i_clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wbp_serialize.md
Name: wbp_serialize

Overview:
- Pipelined-Wishbone front end that sits directly upstream of the pipelined-to-classic bridge.
- Accepts up to 2^LGFIFO back-to-back pipelined requests from a master and queues them in a request FIFO.
- Issues them downstream strictly one at a time, waiting for each ack/err before the next strobe, so the downstream single-outstanding stage never sees overlap.
- Returns acks/errs to the master in order.

Parameters:
- AW, 12, address width
- DW, 32, data width (multiple of 8)
- LGFIFO, 2, log2 of request FIFO depth and of the maximum master-side outstanding count

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_mcyc, i_mstb, i_mwe  in  1 each  master cycle, strobe, write enable
- i_maddr  in  AW  master address
- i_mdata  in  DW  master write data
- i_msel  in  DW/8  master byte select
- o_mstall  out  1  master stall
- o_mack  out  1  master ack
- o_merr  out  1  master bus error
- o_mdata  out  DW  master read data
- o_scyc, o_sstb, o_swe  out  1 each  downstream cycle, strobe, write enable
- o_saddr  out  AW  downstream address
- o_sdata  out  DW  downstream write data
- o_ssel  out  DW/8  downstream byte select
- i_sstall  in  1  downstream stall
- i_sack  in  1  downstream ack
- i_serr  in  1  downstream error
- i_sdata  in  DW  downstream read data

Behaviour:
- Reset values: state IDLE, FIFO empty, count=0, o_mack=0, o_merr=0, o_sstb=0, o_scyc=0, o_mdata=0.
- Accept: i_mcyc && i_mstb && !o_mstall pushes {i_mwe,i_maddr,i_mdata,i_msel}.
- Outstanding count: +1 on accept, -1 when o_mack or o_merr is high; simultaneous +1/-1 leaves it unchanged.
- o_mstall (combinational) = (count == 2^LGFIFO) || state==ERR.
- States and transitions:
  - IDLE: FIFO non-empty -> ISSUE.
  - ISSUE: o_sstb=1, o_s* driven from FIFO head. Pop and go to WAIT when !i_sstall.
  - WAIT: i_sack -> IDLE; i_serr -> ERR.
  - ERR: hold until !i_mcyc -> IDLE.
- o_scyc = i_mcyc && (state != IDLE || FIFO non-empty).
- o_swe: held from the head entry while the transaction is in ISSUE and WAIT.
- Latency:
  - Request accepted at cycle N gives earliest o_sstb at N+1.
  - i_sack at M gives o_mack at M+1 (registered).
  - Next strobe no earlier than M+1.
  - i_sack and i_serr in the same cycle are treated as err.
- o_mdata: loads i_sdata on i_sack in WAIT; otherwise holds.
- Errors:
  - o_merr = single-cycle pulse, registered, i_mcyc-gated.
  - On err, remaining queued entries are discarded without issue; their acks are never returned.
  - Count clears to 0 when leaving ERR.
- i_mcyc drop (any state): next cycle FIFO flushed, count=0, state=IDLE, o_scyc=0, o_mack/o_merr=0. A downstream ack arriving in that cycle is ignored.
- FIFO full + accept blocked by o_mstall: no push. Pop from empty FIFO is impossible by construction.
- Reset mid-transaction: same as the cyc-drop flush; outputs return to reset values next cycle.
- Ack/err are only produced for accepted requests; o_mack and o_merr are never both high.

Optional Feature:
- Macro WBP_SERIALIZE_LOWPOWER_EN.
- Defined: o_saddr, o_sdata, o_ssel forced to zero whenever o_sstb=0.
- Undefined: they always reflect the FIFO head (don't-care when o_sstb=0).

Decomposition:
- Shared package: state encoding constants (IDLE, ISSUE, WAIT, ERR) and the request-entry bit width (1+AW+DW+DW/8).
- One sub-module, wbp_req_fifo: synchronous FIFO with push, pop, full, empty, and flush (same-cycle flush dominates push).

Test Plan:
- Single read: one accepted read to addr 0x010; slave acks 2 cycles after strobe with i_sdata=0xDEADBEEF -> exactly one o_mack, o_mdata=0xDEADBEEF, o_sstb high exactly 1 cycle.
- 4 back-to-back writes to 0x100..0x103 (LGFIFO=2); slave stalls 1 cycle per strobe -> o_mstall never high during entry, downstream strobes are in order and never overlap, 4 o_macks.
- 5 requests with slave ack delayed 10 cycles -> o_mstall high on the 5th request while count=4, 5th accepted the cycle after the first o_mack.
- 3 queued reads; i_serr on the first -> one o_merr pulse, no further o_sstb, o_mstall high until i_mcyc drops, then count=0.
- i_mcyc dropped while in WAIT with 2 queued -> o_scyc low next cycle, FIFO empty, late i_sack produces no o_mack.
- i_reset asserted during ISSUE -> all outputs at reset values the next cycle; a new read afterwards completes normally.
